// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, MEM_BUSY, IF_BUSY} arb_state_t;
   localparam int RWTYPE_W = 3;
   localparam logic [RWTYPE_W-1:0] RWTYPE_WORD = 3'b010;
   typedef struct packed {
      logic                we;
      logic [RWTYPE_W-1:0] rwtype;
      logic [31:0]         addr;
      logic [31:0]         wdata;
   } arb_req_t;
endpackage

// File: rtl/mem_port_arbiter_tracker.sv
// arb_port_tracker: per-port served bit, read-data hold register and stall/rdata outputs.
module arb_port_tracker
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic        req,
   input  logic        busy,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        served,
   output logic        stall,
   output logic [31:0] rdata
);
   logic        done;
   logic [31:0] hold;
   assign done  = busy & bus_ready;
   // stall is gated by rst_n so it drops in the same cycle reset asserts
   assign stall = rst_n & req & ~served & ~done;
   assign rdata = done ? bus_rdata : hold;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         served <= 1'b0;
         hold   <= '0;
      end else begin
         served <= advance ? 1'b0 : (done ? 1'b1 : served);
         if (done) hold <= bus_rdata;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory bus between fetch and the
// MEM-stage data port (data has priority), with per-port stalls and a bus watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                advance,
   input  logic                if_req,
   input  logic [31:0]         if_addr,
   output logic [31:0]         if_rdata,
   output logic                if_stall,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [RWTYPE_W-1:0] mem_rwtype,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   output logic [31:0]         mem_rdata,
   output logic                mem_stall,
   output logic                bus_req,
   output logic                bus_we,
   output logic [RWTYPE_W-1:0] bus_rwtype,
   output logic [31:0]         bus_addr,
   output logic [31:0]         bus_wdata,
   input  logic                bus_ready,
   input  logic [31:0]         bus_rdata,
   output logic                timeout_err
);
   localparam logic [7:0] MAXW = 8'(MAX_WAIT);
   arb_state_t state, next;
   arb_req_t   lat;
   logic [7:0] cnt, cnt_nxt;
   logic       mem_served, if_served, mem_busy, if_busy;
   assign mem_busy   = state == MEM_BUSY;
   assign if_busy    = state == IF_BUSY;
   assign bus_req    = mem_busy | if_busy;
   assign bus_we     = lat.we;
   assign bus_rwtype = lat.rwtype;
   assign bus_addr   = lat.addr;
   assign bus_wdata  = lat.wdata;
   always_comb begin
      next = state;
      if (state == IDLE)
         next = (mem_req & ~mem_served) ? MEM_BUSY : (if_req & ~if_served) ? IF_BUSY : IDLE;
      else if (bus_ready)
         next = IDLE;
      // counter sits at zero while idle, so every BUSY entry starts from zero
      cnt_nxt = (state == IDLE) ? 8'd0 : (!bus_ready && cnt != MAXW) ? cnt + 8'd1 : cnt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lat         <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= next;
         cnt         <= cnt_nxt;
         timeout_err <= timeout_err | (cnt_nxt == MAXW);
         if (state == IDLE && next == MEM_BUSY)
            lat <= '{mem_we, mem_rwtype, mem_addr, mem_wdata};
         else if (state == IDLE && next == IF_BUSY)
            lat <= '{1'b0, RWTYPE_WORD, if_addr, 32'd0};
      end
   end
   arb_port_tracker u_mem (
      .clk(clk), .rst_n(rst_n), .advance(advance), .req(mem_req), .busy(mem_busy),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata), .served(mem_served),
      .stall(mem_stall), .rdata(mem_rdata)
   );
   arb_port_tracker u_if (
      .clk(clk), .rst_n(rst_n), .advance(advance), .req(if_req), .busy(if_busy),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata), .served(if_served),
      .stall(if_stall), .rdata(if_rdata)
   );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, stalls, exactly-once stores,
// watchdog and asynchronous reset, with hand-computed expectations.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0, advance = 1'b0;
   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, bus_ready = 1'b0;
   logic [2:0]  mem_rwtype = 3'b010;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic        if_stall, mem_stall, bus_req, bus_we, timeout_err;
   logic [2:0]  bus_rwtype;
   int          checks = 0, failures = 0, stores = 0;

   mem_port_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .advance(advance),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_rwtype(mem_rwtype), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_rwtype(bus_rwtype), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_mem_stall", 32'(mem_stall), 0);
      chk("rst_if_stall", 32'(if_stall), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_bus_addr", bus_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // single load, ready two cycles after bus_req
      mem_req = 1; mem_we = 0; mem_rwtype = 3'b100; mem_addr = 32'h100; #1;
      chk("ld_w0_stall", 32'(mem_stall), 1);
      chk("ld_w0_busreq", 32'(bus_req), 0);
      cyc(); #1;
      chk("ld_w1_busreq", 32'(bus_req), 1);
      chk("ld_w1_addr", bus_addr, 32'h100);
      chk("ld_w1_rwtype", 32'(bus_rwtype), 4);
      chk("ld_w1_stall", 32'(mem_stall), 1);
      cyc(); #1;
      chk("ld_w2_stall", 32'(mem_stall), 1);
      cyc();
      bus_ready = 1; bus_rdata = 32'hDEADBEEF; advance = 1; #1;
      chk("ld_w3_stall", 32'(mem_stall), 0);
      chk("ld_w3_rdata", mem_rdata, 32'hDEADBEEF);
      cyc();
      bus_ready = 0; bus_rdata = 32'h0; advance = 0; mem_req = 0; #1;
      chk("ld_hold_rdata", mem_rdata, 32'hDEADBEEF);
      chk("ld_hold_busreq", 32'(bus_req), 0);
      cyc();

      // contention: MEM store first, then fetch
      if_req = 1; if_addr = 32'h200; mem_req = 1; mem_we = 1; mem_addr = 32'h300;
      mem_wdata = 32'h55; #1;
      chk("ct_w0_mstall", 32'(mem_stall), 1);
      chk("ct_w0_istall", 32'(if_stall), 1);
      cyc();
      bus_ready = 1; bus_rdata = 32'hAAAA0001; #1;
      chk("ct_w1_addr", bus_addr, 32'h300);
      chk("ct_w1_we", 32'(bus_we), 1);
      chk("ct_w1_wdata", bus_wdata, 32'h55);
      chk("ct_w1_mstall", 32'(mem_stall), 0);
      chk("ct_w1_istall", 32'(if_stall), 1);
      cyc();
      bus_ready = 0; #1;
      chk("ct_w2_busreq", 32'(bus_req), 0);
      chk("ct_w2_mstall", 32'(mem_stall), 0);
      chk("ct_w2_istall", 32'(if_stall), 1);
      cyc();
      bus_ready = 1; bus_rdata = 32'h13; advance = 1; #1;
      chk("ct_w3_addr", bus_addr, 32'h200);
      chk("ct_w3_we", 32'(bus_we), 0);
      chk("ct_w3_rwtype", 32'(bus_rwtype), 2);
      chk("ct_w3_istall", 32'(if_stall), 0);
      chk("ct_w3_irdata", if_rdata, 32'h13);
      chk("ct_w3_mrdata", mem_rdata, 32'hAAAA0001);
      cyc();
      bus_ready = 0; advance = 0; if_req = 0; mem_req = 0;
      cyc();

      // exactly-once store while the pipeline is frozen by a pending fetch
      mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h1234;
      if_req = 1; if_addr = 32'h500; #1;
      cyc();
      bus_ready = 1; #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w1_wdata", bus_wdata, 32'h1234);
      chk("eo_w1_mstall", 32'(mem_stall), 0);
      cyc();
      bus_ready = 0; #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w2_mstall", 32'(mem_stall), 0);
      chk("eo_w2_istall", 32'(if_stall), 1);
      cyc(); #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w3_mstall", 32'(mem_stall), 0);
      chk("eo_w3_addr", bus_addr, 32'h500);
      cyc();
      bus_ready = 1; bus_rdata = 32'h99; #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w4_mstall", 32'(mem_stall), 0);
      chk("eo_w4_irdata", if_rdata, 32'h99);
      cyc();
      bus_ready = 0; #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w5_mstall", 32'(mem_stall), 0);
      chk("eo_w5_busreq", 32'(bus_req), 0);
      cyc();
      advance = 1; #1;
      if (bus_req && bus_we) stores++;
      chk("eo_w6_mstall", 32'(mem_stall), 0);
      chk("eo_store_count", 32'(stores), 1);
      cyc();
      advance = 0; mem_req = 0; if_req = 0; mem_we = 0;
      cyc();

      // back-to-back fetches with bus_ready permanently high
      for (int i = 0; i < 4; i++) begin
         if_req = 1; if_addr = 32'h1000 + 32'(4 * i); bus_ready = 1;
         bus_rdata = 32'hBAD; advance = 0; #1;
         chk("ir_idle_busreq", 32'(bus_req), 0);
         chk("ir_idle_istall", 32'(if_stall), 1);
         cyc();
         bus_rdata = 32'hA0 + 32'(i); advance = 1; #1;
         chk("ir_busreq", 32'(bus_req), 1);
         chk("ir_addr", bus_addr, 32'h1000 + 32'(4 * i));
         chk("ir_we", 32'(bus_we), 0);
         chk("ir_rwtype", 32'(bus_rwtype), 2);
         chk("ir_istall", 32'(if_stall), 0);
         chk("ir_rdata", if_rdata, 32'hA0 + 32'(i));
         cyc();
      end
      if_req = 0; advance = 0; bus_ready = 0;
      cyc();

      // watchdog with MAX_WAIT=4
      mem_req = 1; mem_we = 0; mem_addr = 32'h600; #1;
      chk("wd_w0_err", 32'(timeout_err), 0);
      cyc(); cyc(); cyc(); cyc(); #1;
      chk("wd_w4_err", 32'(timeout_err), 0);
      cyc(); #1;
      chk("wd_w5_err", 32'(timeout_err), 1);
      chk("wd_w5_mstall", 32'(mem_stall), 1);
      bus_ready = 1; bus_rdata = 32'h77; advance = 1; #1;
      chk("wd_w5_done", 32'(mem_stall), 0);
      chk("wd_w5_rdata", mem_rdata, 32'h77);
      cyc();
      bus_ready = 0; advance = 0; mem_req = 0; #1;
      chk("wd_sticky", 32'(timeout_err), 1);
      cyc();

      // asynchronous reset in the middle of a MEM access
      mem_req = 1; mem_addr = 32'h700; #1;
      cyc(); #1;
      chk("ra_busreq", 32'(bus_req), 1);
      chk("ra_mstall", 32'(mem_stall), 1);
      #1 rst_n = 0; #1;
      chk("ra_rst_busreq", 32'(bus_req), 0);
      chk("ra_rst_mstall", 32'(mem_stall), 0);
      chk("ra_rst_err", 32'(timeout_err), 0);
      chk("ra_rst_addr", bus_addr, 0);
      @(negedge clk);
      rst_n = 1; #1;
      chk("ra_idle_busreq", 32'(bus_req), 0);
      chk("ra_idle_mstall", 32'(mem_stall), 1);
      cyc(); #1;
      chk("ra_re_busreq", 32'(bus_req), 1);
      chk("ra_re_addr", bus_addr, 32'h700);
      bus_ready = 1; bus_rdata = 32'h4242; advance = 1; #1;
      chk("ra_re_done", mem_rdata, 32'h4242);
      chk("ra_re_mstall", 32'(mem_stall), 0);
      cyc();
      bus_ready = 0; advance = 0; mem_req = 0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
